decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined instruction-decode stage sitting between fetch and execute. Each accepted 32-bit instruction is registered, decoded into a `control_t` control word, and split into register indices, sign-extended immediate, and jump/branch targets. A two-entry skid buffer with valid/ready handshakes on both sides lets execute stall without a combinational ready path back to fetch.

## Interface
Parameters:
- `DATA_W`, 32: instruction, PC and immediate width; only 32 is supported.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `flush`, in, 1: synchronous; discards every held and incoming instruction.
- `in_valid`, in, 1: fetch presents an instruction.
- `in_ready`, out, 1: stage can accept; registered, never depends combinationally on `out_ready`.
- `instruction`, in, 32: raw instruction word.
- `pc_plus4`, in, 32: fetch PC + 4 for this instruction.
- `out_valid`, out, 1: decoded bundle valid.
- `out_ready`, in, 1: execute accepts the bundle.
- `ctrl`, out, `control_t`: `rf_we`, `sel_wa`, `sel_alu_b`, `dmem_we`, `sel_result`, `sel_pc`, `alu_op`.
- `rs`, `rt`, `rd`, out, 5 each: register fields.
- `shamt`, out, 5: shift amount; `funct`, out, 6: function field.
- `sign_imm`, out, 32: `{{16{imm[15]}}, imm}`.
- `branch_target`, out, 32: `pc_plus4 + (sign_imm << 2)`, modulo 2^32.
- `jump_target`, out, 32: `{pc_plus4[31:28], address, 2'b00}`.
- `illegal`, out, 1: opcode or funct not decodable.

## Operation
- Decode is combinational on the incoming word; the result is captured into the main register (M) on acceptance (`in_valid && in_ready`).
- Opcode map:
  - `0x00` R-type: RF_WE_ENABLE, SEL_WA_WA1, SEL_ALU_B_RT, DMEM_WE_DISABLE, SEL_RESULT_ALU, SEL_PC_PC_PLUS4, ALU_OP_RTYPE.
  - `0x23` lw: RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI.
  - `0x2B` sw: RF_WE_DISABLE, SEL_ALU_B_SIGN_IMM, DMEM_WE_ENABLE, ALU_OP_ADDI.
  - `0x08` addi: RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, SEL_RESULT_ALU, ALU_OP_ADDI.
  - `0x04` beq: RF_WE_DISABLE, SEL_ALU_B_RT, SEL_PC_BRANCH, ALU_OP_SUB. Taken/not-taken is resolved in execute.
  - `0x02` j: RF_WE_DISABLE, DMEM_WE_DISABLE, SEL_PC_JUMP.
- Any other opcode: `illegal=1`, and `ctrl` is forced to NOP_CTRL (RF_WE_DISABLE, DMEM_WE_DISABLE, SEL_PC_PC_PLUS4, remaining fields at encoding 0). The bundle is still passed downstream.
- Skid behaviour: when M holds valid data and `out_ready=0`, a simultaneous acceptance goes to skid register S. `in_ready` deasserts the cycle after S fills. When the output is consumed, S moves into M, and S empties the following cycle.
- Ordering is strictly FIFO. There is no drop or duplicate under any `in_valid`/`out_ready` pattern.

## Timing
- Reset (and flush) outcome: `out_valid=0`, `in_ready=1`, `ctrl=NOP_CTRL`, `illegal=0`, all data outputs 0.
- Reset is sampled before flush; both take effect on the same edge and both discard an acceptance on that edge.
- Latency: an instruction accepted at edge N is presented with `out_valid=1` after edge N.
- Throughput: 1 per cycle while `out_ready=1`.
- Full: both M and S valid. Then `in_ready=0`, and `out_valid` stays 1 with a stable bundle.
- Simultaneous consume and accept with S empty: M is replaced, with no bubble.
- Outputs are stable while `out_valid && !out_ready` (AXI-style hold).
- `flush` mid-stall clears M and S; `in_ready=1` the next cycle.
- Target arithmetic wraps silently; there is no overflow flag.

## Structure
- Package `control_signals`:
  - Existing enums and `control_t`.
  - Enum values added there: SEL_WA_WA1, SEL_ALU_B_RT, SEL_RESULT_ALU, SEL_PC_BRANCH, DMEM_WE_ENABLE, ALU_OP_RTYPE, ALU_OP_SUB.
  - The `NOP_CTRL` constant.
  - A `decoded_t` struct for the full output bundle.
- Package `global_types`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J).
- Sub-module `skid_buffer`, parameterised on payload type. It holds M, S and the handshake logic. The decode logic lives in `decode_stage` itself.

## Test plan
- Reset held for 3 cycles, then released → `out_valid=0`, `in_ready=1`, `ctrl==NOP_CTRL`.
- lw `0x8FA8FFFC`, `pc_plus4=0x00400004` → next cycle:
  - `rs=29`, `rt=8`, `sign_imm=0xFFFFFFFC`.
  - `ctrl`: RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, SEL_RESULT_RD.
- Branch and jump targets:
  - beq `0x1109FFFF`, `pc_plus4=0x00000000` → `branch_target=0xFFFFFFFC` (wrap), `sel_pc=SEL_PC_BRANCH`.
  - j `0x08100003`, `pc_plus4=0x40000010` → `jump_target=0x4040000C`.
- Stream of 6 instructions, `out_ready=0` from cycle 1 to cycle 4 → `in_ready` drops after the 2nd acceptance. When released, all 6 emerge in order with no loss or duplication.
- Stall with M and S full, assert `flush` → next cycle `out_valid=0`, `in_ready=1`, and nothing held is emitted.
- Opcode `0x3F` word `0xFC000000` → `illegal=1`, `ctrl==NOP_CTRL`, `out_valid=1`.

Source files
------------

// File: rtl/control_signals.sv
// control_signals: control word encodings and the decoded bundle carried to execute
package control_signals;
  typedef enum logic {RF_WE_DISABLE, RF_WE_ENABLE} rf_we_t;
  typedef enum logic {SEL_WA_WA0, SEL_WA_WA1} sel_wa_t;
  typedef enum logic {SEL_ALU_B_SIGN_IMM, SEL_ALU_B_RT} sel_alu_b_t;
  typedef enum logic {DMEM_WE_DISABLE, DMEM_WE_ENABLE} dmem_we_t;
  typedef enum logic {SEL_RESULT_RD, SEL_RESULT_ALU} sel_result_t;
  typedef enum logic [1:0] {SEL_PC_PC_PLUS4, SEL_PC_BRANCH, SEL_PC_JUMP} sel_pc_t;
  typedef enum logic [1:0] {ALU_OP_ADDI, ALU_OP_SUB, ALU_OP_RTYPE} alu_op_t;
  typedef struct packed {
    rf_we_t      rf_we;
    sel_wa_t     sel_wa;
    sel_alu_b_t  sel_alu_b;
    dmem_we_t    dmem_we;
    sel_result_t sel_result;
    sel_pc_t     sel_pc;
    alu_op_t     alu_op;
  } control_t;
  // All-zero encoding, so a cleared bundle register already reads as NOP
  localparam control_t NOP_CTRL = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE,
                                    SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
  typedef struct packed {
    control_t    ctrl;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] sign_imm, branch_target, jump_target;
    logic        illegal;
  } decoded_t;
endpackage

// File: rtl/global_types.sv
// global_types: opcode constants shared across the pipeline
package global_types;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready register slice with a registered in_ready
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  logic s_valid;
  T s_data;
  logic accept;
  // in_ready comes straight from a flop, cutting the ready path from execute to fetch
  assign in_ready = !s_valid;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clock)
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_data <= '0;
      s_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      out_valid <= s_valid || accept;
      out_data <= s_valid ? s_data : accept ? in_data : out_data;
      s_valid <= 1'b0;
    end else if (accept) begin
      s_valid <= 1'b1;
      s_data <= in_data;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes fetched instructions into control and operand fields behind a skid buffer
module decode_stage
  import control_signals::*;
  import global_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              out_valid,
  input  logic              out_ready,
  output control_t          ctrl,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] sign_imm,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] jump_target,
  output logic              illegal
);
  control_t c;
  logic bad;
  logic funct_ok;
  logic [31:0] imm;
  decoded_t d, q;
  assign funct_ok = instruction[5:0] inside {6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign imm = {{16{instruction[15]}}, instruction[15:0]};
  always_comb begin
    c = NOP_CTRL;
    bad = 1'b0;
    case (instruction[31:26])
      OP_RTYPE: if (funct_ok) c = '{RF_WE_ENABLE, SEL_WA_WA1, SEL_ALU_B_RT, DMEM_WE_DISABLE, SEL_RESULT_ALU, SEL_PC_PC_PLUS4, ALU_OP_RTYPE};
                else bad = 1'b1;
      OP_LW:    c = '{RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
      OP_SW:    c = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_ENABLE, SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
      OP_ADDI:  c = '{RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_ALU, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
      OP_BEQ:   c = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_RT, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_BRANCH, ALU_OP_SUB};
      OP_J:     c = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_JUMP, ALU_OP_ADDI};
      default:  bad = 1'b1;
    endcase
  end
  assign d = '{ctrl: c, rs: instruction[25:21], rt: instruction[20:16], rd: instruction[15:11],
               shamt: instruction[10:6], funct: instruction[5:0], sign_imm: imm,
               branch_target: pc_plus4 + {imm[29:0], 2'b00},
               jump_target: {pc_plus4[31:28], instruction[25:0], 2'b00}, illegal: bad};
  skid_buffer #(.T(decoded_t)) u_skid (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(q)
  );
  assign {ctrl, rs, rt, rd, shamt, funct, sign_imm, branch_target, jump_target, illegal} = q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with a queue scoreboard checking decoded bundles in order
module tb_decode_stage;
  import control_signals::*;
  logic clock = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instruction, pc_plus4, sign_imm, branch_target, jump_target;
  control_t ctrl;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] funct;
  decoded_t act, held, e;
  decoded_t exp_q[$];
  decoded_t vexp[8];
  logic [31:0] vin[8], vpc[8];
  logic have_held = 1'b0;
  int checks = 0, fails = 0, n_out = 0;

  localparam control_t C_LW   = '{RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
  localparam control_t C_BEQ  = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_RT, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_BRANCH, ALU_OP_SUB};
  localparam control_t C_J    = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_JUMP, ALU_OP_ADDI};
  localparam control_t C_R    = '{RF_WE_ENABLE, SEL_WA_WA1, SEL_ALU_B_RT, DMEM_WE_DISABLE, SEL_RESULT_ALU, SEL_PC_PC_PLUS4, ALU_OP_RTYPE};
  localparam control_t C_SW   = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_ENABLE, SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
  localparam control_t C_ADDI = '{RF_WE_ENABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_ALU, SEL_PC_PC_PLUS4, ALU_OP_ADDI};
  localparam control_t C_NOP  = '{RF_WE_DISABLE, SEL_WA_WA0, SEL_ALU_B_SIGN_IMM, DMEM_WE_DISABLE, SEL_RESULT_RD, SEL_PC_PC_PLUS4, ALU_OP_ADDI};

  decode_stage #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction), .pc_plus4(pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .sign_imm(sign_imm), .branch_target(branch_target), .jump_target(jump_target), .illegal(illegal)
  );

  always #5 clock = ~clock;
  assign act = {ctrl, rs, rt, rd, shamt, funct, sign_imm, branch_target, jump_target, illegal};

  function automatic decoded_t mk(input control_t c, input logic [4:0] a, b, d, s, input logic [5:0] f,
                                  input logic [31:0] si, bt, jt, input logic il);
    return {c, a, b, d, s, f, si, bt, jt, il};
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Entered and left on a falling edge; in_ready is stable there until the next rising edge
  task automatic send(input int k);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end else begin
      in_valid = 1'b1;
      instruction = vin[k];
      pc_plus4 = vpc[k];
      exp_q.push_back(vexp[k]);
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(name, 160'(exp_q.size()), 160'(0));
  endtask

  always begin
    @(negedge clock);
    #1;
    if (reset || flush) have_held = 1'b0;
    else begin
      if (out_valid && have_held) check("hold", 160'(act), 160'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bundle%0d", n_out), 160'(act), 160'(e));
          n_out++;
        end
      end
      have_held = out_valid && !out_ready;
      held = act;
    end
  end

  initial begin
    vin[0] = 32'h8FA8FFFC; vpc[0] = 32'h00400004;
    vexp[0] = mk(C_LW, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3C, 32'hFFFFFFFC, 32'h003FFFF4, 32'h0EA3FFF0, 1'b0);
    vin[1] = 32'h1109FFFF; vpc[1] = 32'h00000000;
    vexp[1] = mk(C_BEQ, 5'd8, 5'd9, 5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0427FFFC, 1'b0);
    vin[2] = 32'h08100003; vpc[2] = 32'h40000010;
    vexp[2] = mk(C_J, 5'd0, 5'd16, 5'd0, 5'd0, 6'h03, 32'h00000003, 32'h4000001C, 32'h4040000C, 1'b0);
    vin[3] = 32'hFC000000; vpc[3] = 32'h00000004;
    vexp[3] = mk(C_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h00000000, 32'h00000004, 32'h00000000, 1'b1);
    vin[4] = 32'h00221820; vpc[4] = 32'h00000100;
    vexp[4] = mk(C_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h00001820, 32'h00006180, 32'h00886080, 1'b0);
    vin[5] = 32'hAC850008; vpc[5] = 32'h00000200;
    vexp[5] = mk(C_SW, 5'd4, 5'd5, 5'd0, 5'd0, 6'h08, 32'h00000008, 32'h00000220, 32'h02140020, 1'b0);
    vin[6] = 32'h20C7FFFE; vpc[6] = 32'h00001000;
    vexp[6] = mk(C_ADDI, 5'd6, 5'd7, 5'd31, 5'd31, 6'h3E, 32'hFFFFFFFE, 32'h00000FF8, 32'h031FFFF8, 1'b0);
    vin[7] = 32'h0000003F; vpc[7] = 32'h00000000;
    vexp[7] = mk(C_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 6'h3F, 32'h0000003F, 32'h000000FC, 32'h000000FC, 1'b1);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 32'h0; pc_plus4 = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 160'(out_valid), 160'(1'b0));
    check("rst_in_ready", 160'(in_ready), 160'(1'b1));
    check("rst_ctrl", 160'(ctrl), 160'(C_NOP));
    check("rst_bundle", 160'(act), 160'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(i);
    drain("drain_stream");
    out_ready = 1'b0;
    send(0);
    send(1);
    check("stall_in_ready", 160'(in_ready), 160'(1'b0));
    check("stall_out_valid", 160'(out_valid), 160'(1'b1));
    fork
      begin
        repeat (2) @(negedge clock);
        out_ready = 1'b1;
      end
    join_none
    for (int i = 2; i < 6; i++) send(i);
    drain("drain_stall");
    out_ready = 1'b0;
    send(4);
    send(5);
    check("full_in_ready", 160'(in_ready), 160'(1'b0));
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 160'(out_valid), 160'(1'b0));
    check("flush_in_ready", 160'(in_ready), 160'(1'b1));
    check("flush_bundle", 160'(act), 160'(0));
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    send(6);
    send(7);
    drain("drain_after_flush");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end
endmodule
